// File: rtl/arm_mem_pkg.sv
// arm_mem_pkg: shared types and constants for the ARM MEM stage and its SRAM
// controller.
//   mem_state_e   - controller FSM states (IDLE, LOW half-word, HIGH half-word, DONE)
//   BASE_ADDR_DEF - byte address that maps to SRAM word 0
//   SRAM_DW       - external SRAM data width
//   word_index()  - byte address to 32-bit word index, relative to the SRAM base
package arm_mem_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOW  = 2'd1,
      S_HIGH = 2'd2,
      S_DONE = 2'd3
   } mem_state_e;

   localparam int unsigned BASE_ADDR_DEF = 32'd1024;
   localparam int unsigned SRAM_DW       = 32'd16;

   // The subtract wraps on addresses below the base; out-of-range accesses
   // simply alias into the SRAM.
   function automatic logic [31:0] word_index(input logic [31:0] byte_addr,
                                              input logic [31:0] base_addr);
      return (byte_addr - base_addr) >> 32'd2;
   endfunction

endpackage

// File: rtl/sram_controller.sv
// sram_controller: moves one 32-bit word to or from a 16-bit asynchronous SRAM
// as two half-word accesses of SRAM_WAIT cycles each (low half first).
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   rd_req       - load request (wins over wr_req when both are set)
//   wr_req       - store request
//   word_addr    - SRAM word index; half-word address is {word_addr, half}
//   wr_data      - store data
//   ready        - 1 when idle with no request, or for the single DONE cycle
//   rd_data      - loaded word {hi, lo}, registered
//   sram_*       - SRAM pins; control and write data are registered
module sram_controller
   import arm_mem_pkg::*;
#(
   parameter int unsigned SRAM_WAIT = 32'd2,
   parameter int unsigned SRAM_AW   = 32'd18
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rd_req,
   input  logic                 wr_req,
   input  logic [SRAM_AW-2:0]   word_addr,
   input  logic [31:0]          wr_data,
   output logic                 ready,
   output logic [31:0]          rd_data,
   output logic [SRAM_AW-1:0]   sram_addr,
   output logic [SRAM_DW-1:0]   sram_wdata,
   input  logic [SRAM_DW-1:0]   sram_rdata,
   output logic                 sram_we_n,
   output logic                 sram_oe_n
);

   localparam int unsigned CNT_W = (SRAM_WAIT > 32'd1) ? $clog2(SRAM_WAIT) : 32'd1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SRAM_WAIT - 32'd1);

   mem_state_e          state_r;
   logic [CNT_W-1:0]    cnt_r;
   logic [SRAM_DW-1:0]  lo_r;
   logic [SRAM_DW-1:0]  hi_r;
   logic                req_s;
   logic                wr_only_s;

   assign req_s     = rd_req | wr_req;
   // A simultaneous read and write is served as a read; the SRAM is never written.
   assign wr_only_s = wr_req & ~rd_req;
   assign rd_data   = {hi_r, lo_r};

   // Access FSM: wait counter, half-word latches and registered SRAM pins.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= S_IDLE;
         cnt_r      <= '0;
         lo_r       <= '0;
         hi_r       <= '0;
         sram_addr  <= '0;
         sram_wdata <= '0;
         sram_we_n  <= 1'b1;
         sram_oe_n  <= 1'b1;
      end else begin
         case (state_r)
            S_IDLE: begin
               if (req_s) begin
                  state_r    <= S_LOW;
                  cnt_r      <= '0;
                  sram_addr  <= {word_addr, 1'b0};
                  sram_wdata <= wr_data[15:0];
                  sram_we_n  <= ~wr_only_s;
                  sram_oe_n  <= ~rd_req;
               end
            end
            S_LOW: begin
               if (cnt_r == CNT_LAST) begin
                  if (rd_req) begin
                     lo_r <= sram_rdata;
                  end
                  state_r    <= S_HIGH;
                  cnt_r      <= '0;
                  sram_addr  <= {word_addr, 1'b1};
                  sram_wdata <= wr_data[31:16];
               end else begin
                  cnt_r <= cnt_r + CNT_W'(1);
               end
            end
            S_HIGH: begin
               if (cnt_r == CNT_LAST) begin
                  if (rd_req) begin
                     hi_r <= sram_rdata;
                  end
                  state_r    <= S_DONE;
                  cnt_r      <= '0;
                  sram_wdata <= '0;
                  sram_we_n  <= 1'b1;
                  sram_oe_n  <= 1'b1;
               end else begin
                  cnt_r <= cnt_r + CNT_W'(1);
               end
            end
            S_DONE: begin
               state_r <= S_IDLE;
            end
            default: begin
               state_r    <= S_IDLE;
               cnt_r      <= '0;
               sram_wdata <= '0;
               sram_we_n  <= 1'b1;
               sram_oe_n  <= 1'b1;
            end
         endcase
      end
   end

   // Ready must drop in the same cycle a request appears, so it is decoded
   // from the state register rather than registered itself.
   always_comb begin
      ready = 1'b0;
      case (state_r)
         S_IDLE: begin
            if (req_s) begin
               ready = 1'b0;
            end else begin
               ready = 1'b1;
            end
         end
         S_DONE:  ready = 1'b1;
         default: ready = 1'b0;
      endcase
   end

endmodule

// File: rtl/mem_stage_sram.sv
// mem_stage_sram: MEM stage of the 5-stage ARM pipeline, between the EX/MEM
// and MEM/WB registers. Loads/stores go to a 16-bit asynchronous SRAM via
// sram_controller; ready=0 freezes the upstream stages for the whole access.
// Ports:
//   clk, rst                       - clock, synchronous active-high reset
//   *_in                           - EX/MEM register outputs (held stable while ready=0)
//   wb_en_out, mem_r_en_out        - to MEM/WB, forced to 0 while ready=0 (bubble)
//   dest_out, alu_result_out       - straight pass-through to MEM/WB
//   mem_data_out                   - loaded word, registered
//   ready                          - 1 = stage may advance, 0 = freeze upstream
//   sram_addr/wdata/rdata/we_n/oe_n- external SRAM interface
module mem_stage_sram
   import arm_mem_pkg::*;
#(
   parameter int unsigned BASE_ADDR = BASE_ADDR_DEF,
   parameter int unsigned SRAM_WAIT = 32'd2,
   parameter int unsigned SRAM_AW   = 32'd18
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wb_en_in,
   input  logic                 mem_r_en_in,
   input  logic                 mem_w_en_in,
   input  logic [3:0]           dest_in,
   input  logic [31:0]          alu_result_in,
   input  logic [31:0]          st_val_in,
   output logic                 wb_en_out,
   output logic                 mem_r_en_out,
   output logic [3:0]           dest_out,
   output logic [31:0]          alu_result_out,
   output logic [31:0]          mem_data_out,
   output logic                 ready,
   output logic [SRAM_AW-1:0]   sram_addr,
   output logic [SRAM_DW-1:0]   sram_wdata,
   input  logic [SRAM_DW-1:0]   sram_rdata,
   output logic                 sram_we_n,
   output logic                 sram_oe_n
);

   logic [SRAM_AW-2:0] word_s;
   logic               ready_s;

   // Half-word address is {word, half}, so the word index loses one bit.
   assign word_s = (SRAM_AW - 32'd1)'(word_index(alu_result_in, BASE_ADDR));

   sram_controller #(
      .SRAM_WAIT (SRAM_WAIT),
      .SRAM_AW   (SRAM_AW)
   ) u_sram_controller (
      .clk        (clk),
      .rst        (rst),
      .rd_req     (mem_r_en_in),
      .wr_req     (mem_w_en_in),
      .word_addr  (word_s),
      .wr_data    (st_val_in),
      .ready      (ready_s),
      .rd_data    (mem_data_out),
      .sram_addr  (sram_addr),
      .sram_wdata (sram_wdata),
      .sram_rdata (sram_rdata),
      .sram_we_n  (sram_we_n),
      .sram_oe_n  (sram_oe_n)
   );

   assign ready          = ready_s;
   assign dest_out       = dest_in;
   assign alu_result_out = alu_result_in;

   // Insert a bubble into MEM/WB while the access is still in flight.
   always_comb begin
      wb_en_out    = 1'b0;
      mem_r_en_out = 1'b0;
      if (ready_s) begin
         wb_en_out    = wb_en_in;
         mem_r_en_out = mem_r_en_in;
      end else begin
         wb_en_out    = 1'b0;
         mem_r_en_out = 1'b0;
      end
   end

endmodule

// File: tb/tb_mem_stage_sram.sv
// tb_mem_stage_sram: directed bench for mem_stage_sram. A default instance
// (SRAM_WAIT=2) talks to a small SRAM array model; a second instance
// (SRAM_WAIT=1) reads from an address-derived pattern. Expected load words
// go through a scoreboard queue and are popped in the DONE cycle.
module tb_mem_stage_sram;

   localparam int unsigned W = 32'd2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        wb_en_in, mem_r_en_in, mem_w_en_in;
   logic [3:0]  dest_in;
   logic [31:0] alu_result_in, st_val_in;
   logic        wb_en_out, mem_r_en_out, ready;
   logic [3:0]  dest_out;
   logic [31:0] alu_result_out, mem_data_out;
   logic [17:0] sram_addr;
   logic [15:0] sram_wdata, sram_rdata;
   logic        sram_we_n, sram_oe_n;
   logic [15:0] sram_mem [0:63];

   logic        b_wb_en_in, b_mem_r_en_in, b_mem_w_en_in;
   logic [3:0]  b_dest_in;
   logic [31:0] b_alu_result_in, b_st_val_in;
   logic        b_wb_en_out, b_mem_r_en_out, b_ready;
   logic [3:0]  b_dest_out;
   logic [31:0] b_alu_result_out, b_mem_data_out;
   logic [17:0] b_sram_addr;
   logic [15:0] b_sram_wdata, b_sram_rdata;
   logic        b_sram_we_n, b_sram_oe_n;

   int          n_cmp  = 0;
   int          n_fail = 0;
   logic [31:0] exp_q [$];
   logic [31:0] last_load;

   mem_stage_sram #(.BASE_ADDR(32'd1024), .SRAM_WAIT(W), .SRAM_AW(32'd18)) u_dut (
      .clk(clk), .rst(rst), .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in),
      .mem_w_en_in(mem_w_en_in), .dest_in(dest_in), .alu_result_in(alu_result_in),
      .st_val_in(st_val_in), .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out),
      .dest_out(dest_out), .alu_result_out(alu_result_out), .mem_data_out(mem_data_out),
      .ready(ready), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
      .sram_rdata(sram_rdata), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n));

   mem_stage_sram #(.BASE_ADDR(32'd1024), .SRAM_WAIT(32'd1), .SRAM_AW(32'd18)) u_dut_w1 (
      .clk(clk), .rst(rst), .wb_en_in(b_wb_en_in), .mem_r_en_in(b_mem_r_en_in),
      .mem_w_en_in(b_mem_w_en_in), .dest_in(b_dest_in), .alu_result_in(b_alu_result_in),
      .st_val_in(b_st_val_in), .wb_en_out(b_wb_en_out), .mem_r_en_out(b_mem_r_en_out),
      .dest_out(b_dest_out), .alu_result_out(b_alu_result_out), .mem_data_out(b_mem_data_out),
      .ready(b_ready), .sram_addr(b_sram_addr), .sram_wdata(b_sram_wdata),
      .sram_rdata(b_sram_rdata), .sram_we_n(b_sram_we_n), .sram_oe_n(b_sram_oe_n));

   // SRAM model for the default instance: write on the edge while we_n is low.
   always @(posedge clk) begin
      if (!sram_we_n) sram_mem[sram_addr[5:0]] <= sram_wdata;
   end
   assign sram_rdata   = sram_oe_n ? 16'h0000 : sram_mem[sram_addr[5:0]];
   // Read-only pattern SRAM for the SRAM_WAIT=1 instance.
   assign b_sram_rdata = b_sram_oe_n ? 16'h0000 : {b_sram_addr[7:0], ~b_sram_addr[7:0]};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Present one memory request and follow it cycle by cycle until ready returns.
   task automatic access(input logic rd, input logic wr, input logic wb, input logic [3:0] dst,
                         input logic [31:0] addr, input logic [31:0] st, input logic [31:0] exp_load);
      logic [16:0] word;
      logic        wr_only, done, hi;
      logic [31:0] popped;
      word    = 17'((addr - 32'd1024) >> 32'd2);
      wr_only = wr & ~rd;
      wb_en_in = wb; mem_r_en_in = rd; mem_w_en_in = wr;
      dest_in = dst; alu_result_in = addr; st_val_in = st;
      if (rd) exp_q.push_back(exp_load);
      done = 1'b0;
      for (int k = 0; k < int'(2 * W + 6) && !done; k++) begin
         #1;
         check("dest_out", 32'(dest_out), 32'(dst));
         check("alu_result_out", alu_result_out, addr);
         if (ready) begin
            done = 1'b1;
            check("stall_len", 32'(k), 32'(1 + 2 * W));
            check("done_we_n", 32'(sram_we_n), 32'd1);
            check("done_oe_n", 32'(sram_oe_n), 32'd1);
            check("done_wb_en_out", 32'(wb_en_out), 32'(wb));
            check("done_mem_r_en_out", 32'(mem_r_en_out), 32'(rd));
            if (rd) begin
               if (exp_q.size() == 0) begin
                  n_cmp++; n_fail++;
                  $error("FAIL scoreboard_empty: observed=0x%08h expected=none", mem_data_out);
               end else begin
                  popped = exp_q.pop_front();
                  check("load_data", mem_data_out, popped);
                  last_load = popped;
               end
            end else begin
               check("hold_data", mem_data_out, last_load);
            end
         end else begin
            check("stall_wb_en_out", 32'(wb_en_out), 32'd0);
            check("stall_mem_r_en_out", 32'(mem_r_en_out), 32'd0);
            if (k == 0) begin
               check("idle_we_n", 32'(sram_we_n), 32'd1);
               check("idle_oe_n", 32'(sram_oe_n), 32'd1);
            end else begin
               hi = (k > int'(W));
               check("sram_addr", 32'(sram_addr), 32'({word, hi}));
               check("sram_we_n", 32'(sram_we_n), 32'(!wr_only));
               check("sram_oe_n", 32'(sram_oe_n), 32'(!rd));
               if (wr_only) check("sram_wdata", 32'(sram_wdata), hi ? 32'(st[31:16]) : 32'(st[15:0]));
            end
         end
         @(posedge clk); #1;
      end
      if (!done) begin
         n_cmp++; n_fail++;
         $error("FAIL access_timeout: observed=ready_low expected=ready_high addr=0x%08h", addr);
      end
   endtask

   task automatic drive_idle();
      wb_en_in = 1'b0; mem_r_en_in = 1'b0; mem_w_en_in = 1'b0;
      dest_in = 4'h0; alu_result_in = 32'h0; st_val_in = 32'h0;
   endtask

   initial begin
      logic done_b;
      rst = 1'b1;
      drive_idle();
      b_wb_en_in = 1'b0; b_mem_r_en_in = 1'b0; b_mem_w_en_in = 1'b0;
      b_dest_in = 4'h0; b_alu_result_in = 32'h0; b_st_val_in = 32'h0;
      last_load = 32'h0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state
      #1;
      check("rst_ready", 32'(ready), 32'd1);
      check("rst_wb_en_out", 32'(wb_en_out), 32'd0);
      check("rst_we_n", 32'(sram_we_n), 32'd1);
      check("rst_oe_n", 32'(sram_oe_n), 32'd1);
      check("rst_addr", 32'(sram_addr), 32'd0);
      check("rst_wdata", 32'(sram_wdata), 32'd0);
      check("rst_mem_data", mem_data_out, 32'd0);
      @(posedge clk); #1;

      // Non-memory op passes straight through
      wb_en_in = 1'b1; dest_in = 4'h3; alu_result_in = 32'h55;
      #1;
      check("pass_ready", 32'(ready), 32'd1);
      check("pass_wb_en_out", 32'(wb_en_out), 32'd1);
      check("pass_mem_r_en_out", 32'(mem_r_en_out), 32'd0);
      check("pass_alu", alu_result_out, 32'h55);
      check("pass_dest", 32'(dest_out), 32'h3);
      check("pass_we_n", 32'(sram_we_n), 32'd1);
      check("pass_oe_n", 32'(sram_oe_n), 32'd1);
      check("pass_wdata", 32'(sram_wdata), 32'd0);
      @(posedge clk); #1;

      // Store then load of the same word
      access(1'b0, 1'b1, 1'b0, 4'h0, 32'd1028, 32'hDEADBEEF, 32'h0);
      check("sram_mem2", 32'(sram_mem[2]), 32'h0000BEEF);
      check("sram_mem3", 32'(sram_mem[3]), 32'h0000DEAD);
      access(1'b1, 1'b0, 1'b1, 4'h5, 32'd1028, 32'h0, 32'hDEADBEEF);

      // Back-to-back load then store, then read the stored word back
      access(1'b1, 1'b0, 1'b1, 4'h6, 32'd1028, 32'h0, 32'hDEADBEEF);
      access(1'b0, 1'b1, 1'b0, 4'h7, 32'd1032, 32'h12345678, 32'h0);
      access(1'b1, 1'b0, 1'b1, 4'h8, 32'd1032, 32'h0, 32'h12345678);
      drive_idle();
      @(posedge clk); #1;

      // Reset in the HIGH phase of a store
      mem_w_en_in = 1'b1; alu_result_in = 32'd1040; st_val_in = 32'hCAFEF00D;
      repeat (W + 1) @(posedge clk);
      #1;
      check("abort_high_addr", 32'(sram_addr), 32'd9);
      check("abort_high_we_n", 32'(sram_we_n), 32'd0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("abort_we_n", 32'(sram_we_n), 32'd1);
      check("abort_oe_n", 32'(sram_oe_n), 32'd1);
      check("abort_addr", 32'(sram_addr), 32'd0);
      check("abort_mem_data", mem_data_out, 32'd0);
      check("abort_ready_req", 32'(ready), 32'd0);
      last_load = 32'h0;
      access(1'b1, 1'b0, 1'b1, 4'h9, 32'd1028, 32'h0, 32'hDEADBEEF);
      drive_idle();

      // SRAM_WAIT=1, read and write both set at the base address
      b_wb_en_in = 1'b1; b_mem_r_en_in = 1'b1; b_mem_w_en_in = 1'b1;
      b_alu_result_in = 32'd1024; b_st_val_in = 32'h11112222;
      exp_q.push_back(32'h01FE00FF);
      done_b = 1'b0;
      for (int k = 0; k < 8 && !done_b; k++) begin
         #1;
         check("w1_we_n", 32'(b_sram_we_n), 32'd1);
         if (b_ready) begin
            done_b = 1'b1;
            check("w1_stall_len", 32'(k), 32'd3);
            check("w1_mem_r_en_out", 32'(b_mem_r_en_out), 32'd1);
            if (exp_q.size() == 0) begin
               n_cmp++; n_fail++;
               $error("FAIL w1_scoreboard_empty: observed=0x%08h expected=none", b_mem_data_out);
            end else begin
               check("w1_load_data", b_mem_data_out, exp_q.pop_front());
            end
         end else begin
            check("w1_stall_wb_en_out", 32'(b_wb_en_out), 32'd0);
            check("w1_oe_n", 32'(b_sram_oe_n), (k == 0) ? 32'd1 : 32'd0);
            if (k > 0) check("w1_addr", 32'(b_sram_addr), 32'(k - 1));
         end
         @(posedge clk); #1;
      end
      if (!done_b) begin
         n_cmp++; n_fail++;
         $error("FAIL w1_timeout: observed=ready_low expected=ready_high");
      end
      b_mem_r_en_in = 1'b0; b_mem_w_en_in = 1'b0;
      @(posedge clk); #1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_stage_sram.md
Name: mem_stage_sram

Overview:
- MEM stage of the 5-stage ARM pipeline, directly downstream of the EX/MEM pipeline register. It consumes that register's outputs and feeds the MEM/WB register.
- Performs data-memory loads/stores against an external 16-bit asynchronous SRAM. Each 32-bit word is transferred as two half-word accesses of SRAM_WAIT cycles each.
- Drives `ready` low while an access is in flight. The hazard/freeze logic uses it to hold the PC and the IF/ID, ID/EX and EX/MEM registers.

Parameters:
- BASE_ADDR, 1024, byte address mapped to SRAM word 0
- SRAM_WAIT, 2, cycles per half-word access (must be >= 1)
- SRAM_AW, 18, SRAM half-word address width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous active-high reset, sampled on the rising edge of clk
- wb_en_in  in  1  write-back enable from EX/MEM
- mem_r_en_in  in  1  load request from EX/MEM
- mem_w_en_in  in  1  store request from EX/MEM
- dest_in  in  4  destination register from EX/MEM
- alu_result_in  in  32  effective address / ALU result from EX/MEM
- st_val_in  in  32  store data from EX/MEM
- wb_en_out  out  1  to MEM/WB; forced 0 while ready=0
- mem_r_en_out  out  1  to MEM/WB; forced 0 while ready=0
- dest_out  out  4  to MEM/WB; equals dest_in
- alu_result_out  out  32  to MEM/WB; equals alu_result_in
- mem_data_out  out  32  loaded word {hi,lo}, registered
- ready  out  1  1 = stage may advance; 0 = freeze upstream
- sram_addr  out  SRAM_AW  half-word address
- sram_wdata  out  16  write data
- sram_rdata  in  16  read data
- sram_we_n  out  1  active-low write enable
- sram_oe_n  out  1  active-low output enable

Behaviour:
- FSM states: IDLE, LOW, HIGH, DONE. `req` = mem_r_en_in | mem_w_en_in.
- IDLE:
  - If req: ready=0, go to LOW, clear cnt.
  - Else: ready=1, stay in IDLE; the stage is a pure pass-through.
- LOW:
  - Drives sram_addr = {word,1'b0}, where word = (alu_result_in - BASE_ADDR) >> 2, truncated to SRAM_AW-1 bits. The unsigned subtract wraps; no range check.
  - cnt increments each cycle. At cnt==SRAM_WAIT-1: for a read, latch sram_rdata into the lo register; then go to HIGH and clear cnt.
- HIGH: same as LOW with sram_addr = {word,1'b1}; at cnt==SRAM_WAIT-1, latch the hi register and go to DONE.
- DONE: ready=1 for exactly one cycle, mem_data_out valid; go to IDLE next edge.
- Stall length: ready=0 for 1+2*SRAM_WAIT cycles after a request is first presented (5 cycles at default).
- Upstream is frozen during the stall, so EX/MEM inputs are stable. The block does not register them.
- Writes:
  - sram_we_n=0 throughout LOW/HIGH when mem_w_en_in and not mem_r_en_in.
  - sram_wdata = st_val_in[15:0] in LOW, st_val_in[31:16] in HIGH, 0 otherwise.
- Reads: sram_oe_n=0 throughout LOW/HIGH when mem_r_en_in. sram_we_n and sram_oe_n are 1 in IDLE and DONE.
- Read and write both asserted: treated as a read; no SRAM write occurs.
- mem_data_out holds its last value across non-load instructions and updates only on latch events.
- Reset (synchronous, also mid-access):
  - State IDLE, cnt=0, lo/hi/mem_data_out=0.
  - sram_we_n=1, sram_oe_n=1, sram_addr=0, sram_wdata=0.
  - ready and wb_en_out follow the IDLE rules on the cycle after reset.
  - An aborted store may leave SRAM partially written; this is accepted.

Decomposition:
- Shared package `arm_mem_pkg`: state enum (IDLE/LOW/HIGH/DONE), BASE_ADDR default, SRAM data width constant 16.
- One sub-module, `sram_controller`: FSM, counter, SRAM pins, lo/hi latches and ready.
- mem_stage_sram wraps it with the address translation and the pass-through/bubble gating.

Test Plan:
- Non-memory op (wb_en_in=1, r/w=0, alu_result_in=0x55) -> ready=1 same cycle; wb_en_out=1; alu_result_out=0x55; SRAM pins idle.
- Store st_val_in=0xDEADBEEF at address 1028 (SRAM_WAIT=2):
  - ready=0 for 5 cycles.
  - sram_addr=2 with wdata=0xBEEF, then sram_addr=3 with wdata=0xDEAD; we_n low 2 cycles each.
  - DONE cycle: ready=1.
- Load from address 1028 with an SRAM model returning that word -> ready=0 for 5 cycles; in DONE, mem_data_out=0xDEADBEEF, wb_en_out=1, mem_r_en_out=1.
- Back-to-back load then store -> second request enters LOW the cycle after DONE→IDLE; no SRAM cycle overlaps; wb_en_out=0 on every stall cycle.
- Reset asserted during HIGH of a store -> next cycle state IDLE, sram_we_n=1, mem_data_out=0; the following load completes normally.
- SRAM_WAIT=1 with read and write both set, address 1024 -> stall 3 cycles; we_n stays 1; mem_data_out = SRAM words 0/1.
